ibuffer: RTL and testbench

- Instruction buffer between the IFU fetch path and the IDU decode stage.
- Circular FIFO: enqueues fetched instructions with their PC and branch-prediction info, and presents the oldest entry show-ahead to the IDU.
- The IDU pops entries with ibuffer_read_en.
- flush_valid from intwb discards every buffered entry.

---
 rtl/ibuffer.sv | 95 +++++++++
 tb/tb_ibuffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer.sv
// Instruction buffer between IFU fetch and IDU decode: circular FIFO of
// {inst, pc, predicttaken, predicttarget} with show-ahead head outputs.
module ibuffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ifu2ibuffer_instr_valid,
    input  logic [31:0]      ifu2ibuffer_inst,
    input  logic [47:0]      ifu2ibuffer_pc,
    input  logic             ifu2ibuffer_predicttaken,
    input  logic [31:0]      ifu2ibuffer_predicttarget,
    output logic             ibuffer2ifu_instr_ready,
    input  logic             ibuffer_read_en,
    output logic             fifo_empty,
    output logic             ibuffer_instr_valid,
    output logic [31:0]      ibuffer_inst_out,
    output logic [47:0]      ibuffer_pc_out,
    output logic             ibuffer_predicttaken_out,
    output logic [31:0]      ibuffer_predicttarget_out,
    output logic [PTR_W:0]   ibuffer_count,
    input  logic             flush_valid
);

    localparam int unsigned AW = PTR_W + 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [47:0] pc;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_enq;
    logic            w_deq;
    entry_t          w_wr_entry;
    entry_t          w_head;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    // Ready depends only on registered state; a same-cycle pop never frees a slot.
    assign w_enq = ifu2ibuffer_instr_valid && !w_full && !flush_valid;
    assign w_deq = ibuffer_read_en && !w_empty && !flush_valid;

    assign w_wr_entry = '{inst:   ifu2ibuffer_inst,
                          pc:     ifu2ibuffer_pc,
                          taken:  ifu2ibuffer_predicttaken,
                          target: ifu2ibuffer_predicttarget};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_enq);
            r_rd_ptr <= r_rd_ptr + AW'(w_deq);
            r_count  <= r_count + AW'(w_enq) - AW'(w_deq);
        end
    end

    // Storage is deliberately left unreset; empty masking hides stale contents.
    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_wr_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign fifo_empty                = w_empty;
    assign ibuffer_instr_valid       = !w_empty;
    assign ibuffer2ifu_instr_ready   = !w_full;
    assign ibuffer_count             = r_count;
    assign ibuffer_inst_out          = w_empty ? 32'd0 : w_head.inst;
    assign ibuffer_pc_out            = w_empty ? 48'd0 : w_head.pc;
    assign ibuffer_predicttaken_out  = w_empty ? 1'b0  : w_head.taken;
    assign ibuffer_predicttarget_out = w_empty ? 32'd0 : w_head.target;

endmodule

// File: tb/tb_ibuffer.sv
// Directed self-checking bench for ibuffer (DEPTH=8).
module tb_ibuffer;

    logic        clock;
    logic        reset;
    logic        ifu2ibuffer_instr_valid;
    logic [31:0] ifu2ibuffer_inst;
    logic [47:0] ifu2ibuffer_pc;
    logic        ifu2ibuffer_predicttaken;
    logic [31:0] ifu2ibuffer_predicttarget;
    logic        ibuffer2ifu_instr_ready;
    logic        ibuffer_read_en;
    logic        fifo_empty;
    logic        ibuffer_instr_valid;
    logic [31:0] ibuffer_inst_out;
    logic [47:0] ibuffer_pc_out;
    logic        ibuffer_predicttaken_out;
    logic [31:0] ibuffer_predicttarget_out;
    logic [3:0]  ibuffer_count;
    logic        flush_valid;

    int checks   = 0;
    int failures = 0;

    ibuffer #(.DEPTH(8)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .ifu2ibuffer_instr_valid   (ifu2ibuffer_instr_valid),
        .ifu2ibuffer_inst          (ifu2ibuffer_inst),
        .ifu2ibuffer_pc            (ifu2ibuffer_pc),
        .ifu2ibuffer_predicttaken  (ifu2ibuffer_predicttaken),
        .ifu2ibuffer_predicttarget (ifu2ibuffer_predicttarget),
        .ibuffer2ifu_instr_ready   (ibuffer2ifu_instr_ready),
        .ibuffer_read_en           (ibuffer_read_en),
        .fifo_empty                (fifo_empty),
        .ibuffer_instr_valid       (ibuffer_instr_valid),
        .ibuffer_inst_out          (ibuffer_inst_out),
        .ibuffer_pc_out            (ibuffer_pc_out),
        .ibuffer_predicttaken_out  (ibuffer_predicttaken_out),
        .ibuffer_predicttarget_out (ibuffer_predicttarget_out),
        .ibuffer_count             (ibuffer_count),
        .flush_valid               (flush_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and let outputs settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic enq_one(input logic [47:0] pc, input logic [31:0] inst);
        ifu2ibuffer_instr_valid = 1'b1;
        ifu2ibuffer_pc          = pc;
        ifu2ibuffer_inst        = inst;
        step();
        ifu2ibuffer_instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", fifo_empty); end
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ibuffer_instr_valid); end
        checks++; if (ibuffer2ifu_instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ibuffer2ifu_instr_ready); end
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ibuffer_count); end
        checks++; if (ibuffer_pc_out !== 48'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", ibuffer_pc_out); end
        ibuffer_read_en = 1'b1;
        step();
        ibuffer_read_en = 1'b0;
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", ibuffer_count); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL empty_pop_empty got=%0b exp=1", fifo_empty); end
    endtask

    task automatic test_single();
        ifu2ibuffer_predicttaken  = 1'b1;
        ifu2ibuffer_predicttarget = 32'h8000_0010;
        enq_one(48'h0000_8000_0000, 32'h0000_0013);
        ifu2ibuffer_predicttaken  = 1'b0;
        ifu2ibuffer_predicttarget = 32'd0;
        checks++; if (ibuffer_instr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", ibuffer_instr_valid); end
        checks++; if (ibuffer_inst_out !== 32'h0000_0013) begin failures++; $display("FAIL single_inst got=%h exp=00000013", ibuffer_inst_out); end
        checks++; if (ibuffer_pc_out !== 48'h0000_8000_0000) begin failures++; $display("FAIL single_pc got=%h exp=000080000000", ibuffer_pc_out); end
        checks++; if (ibuffer_predicttaken_out !== 1'b1) begin failures++; $display("FAIL single_taken got=%0b exp=1", ibuffer_predicttaken_out); end
        checks++; if (ibuffer_predicttarget_out !== 32'h8000_0010) begin failures++; $display("FAIL single_target got=%h exp=80000010", ibuffer_predicttarget_out); end
        checks++; if (ibuffer_count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", ibuffer_count); end
        ibuffer_read_en = 1'b1;
        step();
        ibuffer_read_en = 1'b0;
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", ibuffer_count); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%0b exp=1", fifo_empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            checks++; if (ibuffer2ifu_instr_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d got=%0b exp=1", i, ibuffer2ifu_instr_ready); end
            enq_one(48'h1000 + 48'(4 * i), 32'(i));
        end
        checks++; if (ibuffer2ifu_instr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", ibuffer2ifu_instr_ready); end
        checks++; if (ibuffer_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", ibuffer_count); end
        checks++; if (ibuffer_pc_out !== 48'h1000) begin failures++; $display("FAIL full_head got=%h exp=1000", ibuffer_pc_out); end
        // Ninth enqueue with a same-cycle pop must still be refused.
        ifu2ibuffer_instr_valid = 1'b1;
        ifu2ibuffer_pc          = 48'h9999;
        ibuffer_read_en         = 1'b1;
        #1;
        checks++; if (ibuffer2ifu_instr_ready !== 1'b0) begin failures++; $display("FAIL full_ready_with_pop got=%0b exp=0", ibuffer2ifu_instr_ready); end
        step();
        ifu2ibuffer_instr_valid = 1'b0;
        checks++; if (ibuffer_count !== 4'd7) begin failures++; $display("FAIL refused_count got=%0d exp=7", ibuffer_count); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (ibuffer_pc_out !== 48'h1000 + 48'(4 * i)) begin failures++; $display("FAIL drain_pc_%0d got=%h exp=%h", i, ibuffer_pc_out, 48'h1000 + 48'(4 * i)); end
            step();
        end
        ibuffer_read_en = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", fifo_empty); end
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", ibuffer_count); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) enq_one(48'h3000 + 48'(4 * k), 32'(k));
        checks++; if (ibuffer_count !== 4'd3) begin failures++; $display("FAIL stream_pre_count got=%0d exp=3", ibuffer_count); end
        ibuffer_read_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ifu2ibuffer_instr_valid = 1'b1;
            ifu2ibuffer_pc          = 48'h3000 + 48'(4 * (n + 3));
            #1;
            checks++; if (ibuffer_pc_out !== 48'h3000 + 48'(4 * n)) begin failures++; $display("FAIL stream_pc_%0d got=%h exp=%h", n, ibuffer_pc_out, 48'h3000 + 48'(4 * n)); end
            step();
            checks++; if (ibuffer_count !== 4'd3) begin failures++; $display("FAIL stream_count_%0d got=%0d exp=3", n, ibuffer_count); end
        end
        ibuffer_read_en         = 1'b0;
        ifu2ibuffer_instr_valid = 1'b0;
        checks++; if (ibuffer_pc_out !== 48'h3050) begin failures++; $display("FAIL stream_tail_pc got=%h exp=3050", ibuffer_pc_out); end
    endtask

    task automatic test_flush();
        enq_one(48'h305C, 32'd23);
        enq_one(48'h3060, 32'd24);
        checks++; if (ibuffer_count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", ibuffer_count); end
        flush_valid             = 1'b1;
        ifu2ibuffer_instr_valid = 1'b1;
        ifu2ibuffer_pc          = 48'hDEAD;
        ifu2ibuffer_inst        = 32'hDEAD_BEEF;
        ibuffer_read_en         = 1'b1;
        step();
        flush_valid             = 1'b0;
        ifu2ibuffer_instr_valid = 1'b0;
        ibuffer_read_en         = 1'b0;
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", ibuffer_count); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b exp=1", fifo_empty); end
        checks++; if (ibuffer_pc_out !== 48'd0) begin failures++; $display("FAIL flush_pc got=%h exp=0", ibuffer_pc_out); end
        checks++; if (ibuffer_inst_out !== 32'd0) begin failures++; $display("FAIL flush_inst got=%h exp=0", ibuffer_inst_out); end
        step();
        checks++; if (ibuffer_instr_valid !== 1'b0) begin failures++; $display("FAIL flush_absent got=%0b exp=0", ibuffer_instr_valid); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) enq_one(48'h4000 + 48'(4 * k), 32'(k));
        checks++; if (ibuffer_count !== 4'd4) begin failures++; $display("FAIL rst_pre_count got=%0d exp=4", ibuffer_count); end
        reset                   = 1'b1;
        flush_valid             = 1'b1;
        ifu2ibuffer_instr_valid = 1'b1;
        ifu2ibuffer_pc          = 48'h5555;
        step();
        reset                   = 1'b0;
        flush_valid             = 1'b0;
        ifu2ibuffer_instr_valid = 1'b0;
        checks++; if (ibuffer_count !== 4'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", ibuffer_count); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got=%0b exp=1", fifo_empty); end
        enq_one(48'h2000, 32'h0000_0093);
        checks++; if (ibuffer_pc_out !== 48'h2000) begin failures++; $display("FAIL rst_after_pc got=%h exp=2000", ibuffer_pc_out); end
        checks++; if (ibuffer_count !== 4'd1) begin failures++; $display("FAIL rst_after_count got=%0d exp=1", ibuffer_count); end
        checks++; if (ibuffer_instr_valid !== 1'b1) begin failures++; $display("FAIL rst_after_valid got=%0b exp=1", ibuffer_instr_valid); end
    endtask

    initial begin
        reset                     = 1'b1;
        ifu2ibuffer_instr_valid   = 1'b0;
        ifu2ibuffer_inst          = 32'd0;
        ifu2ibuffer_pc            = 48'd0;
        ifu2ibuffer_predicttaken  = 1'b0;
        ifu2ibuffer_predicttarget = 32'd0;
        ibuffer_read_en           = 1'b0;
        flush_valid               = 1'b0;
        step();
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
